// File: rtl/cyl_to_rect.sv
// Cylindrical-to-rectangular converter: 8-step CORDIC rotation of (r, 0) by theta, with a quadrant fold.
// Optional radius pre-scaling for CORDIC gain compensation is enabled by defining CYL2RECT_GAIN_COMP_EN.
module cyl_to_rect (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        r_in,
   input  logic signed [7:0] theta_in,
   input  logic signed [7:0] z_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [9:0] x_out,
   output logic signed [9:0] y_out,
   output logic signed [7:0] z_out
);

   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

   state_t             r_state, w_nextState;
   logic signed [11:0] r_x, r_y, r_z;
   logic [2:0]         r_iter;
   logic               r_outValid;

   logic signed [11:0] w_rs, w_theta16, w_x0, w_y0, w_z0;
   logic signed [11:0] w_xSh, w_ySh, w_xNew, w_yNew, w_zNew, w_angle;
   logic               w_accept, w_release;

`ifdef CYL2RECT_GAIN_COMP_EN
   // 155/256 ~= 1/1.6468 cancels the CORDIC gain so the result magnitude tracks r
   logic [15:0] w_rScaled;
   assign w_rScaled = r_in * 8'd155;
   assign w_rs      = 12'(w_rScaled >> 8);
`else
   assign w_rs = {4'b0000, r_in};
`endif

   assign w_theta16 = {theta_in, 4'b0000};
   assign w_accept  = in_valid && (r_state == IDLE);
   assign w_release = (r_state == DONE) && r_outValid && out_ready;
   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_outValid;

   // Angles beyond +/-90 are pre-rotated so the residual stays inside CORDIC convergence range
   always_comb begin
      w_x0 = w_rs;
      w_y0 = '0;
      w_z0 = w_theta16;
      if (theta_in > 8'sd90) begin
         w_x0 = '0;
         w_y0 = w_rs;
         w_z0 = w_theta16 - 12'sd1440;
      end else if (theta_in < -8'sd90) begin
         w_x0 = '0;
         w_y0 = -w_rs;
         w_z0 = w_theta16 + 12'sd1440;
      end
   end

   always_comb begin
      w_angle = 12'sd0;
      case (r_iter)
         3'd0: w_angle = 12'sd720;
         3'd1: w_angle = 12'sd425;
         3'd2: w_angle = 12'sd225;
         3'd3: w_angle = 12'sd114;
         3'd4: w_angle = 12'sd57;
         3'd5: w_angle = 12'sd29;
         3'd6: w_angle = 12'sd14;
         3'd7: w_angle = 12'sd7;
         default: w_angle = 12'sd0;
      endcase
   end

   assign w_xSh = r_x >>> r_iter;
   assign w_ySh = r_y >>> r_iter;

   always_comb begin
      w_xNew = r_x - w_ySh;
      w_yNew = r_y + w_xSh;
      w_zNew = r_z - w_angle;
      if (r_z[11]) begin
         w_xNew = r_x + w_ySh;
         w_yNew = r_y - w_xSh;
         w_zNew = r_z + w_angle;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_nextState = ITER;
         ITER:    if (r_iter == 3'd7) w_nextState = DONE;
         DONE:    if (w_release) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // out_valid lags entry into DONE by one cycle, giving a 9-clock accept-to-valid latency
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_iter     <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_z        <= '0;
         x_out      <= '0;
         y_out      <= '0;
         z_out      <= '0;
         r_outValid <= 1'b0;
      end else begin
         r_state    <= w_nextState;
         r_outValid <= (r_state == DONE) && !w_release;
         if (w_accept) begin
            r_x    <= w_x0;
            r_y    <= w_y0;
            r_z    <= w_z0;
            r_iter <= '0;
            z_out  <= z_in;
         end else if (r_state == ITER) begin
            r_x    <= w_xNew;
            r_y    <= w_yNew;
            r_z    <= w_zNew;
            r_iter <= r_iter + 3'd1;
            if (r_iter == 3'd7) begin
               x_out <= w_xNew[9:0];
               y_out <= w_yNew[9:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_cyl_to_rect.sv
// Self-checking bench for cyl_to_rect: directed table, randomized vectors against a CORDIC model,
// DONE back-pressure and mid-conversion reset. Honours CYL2RECT_GAIN_COMP_EN for expected values.
module tb_cyl_to_rect;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        r_in;
   logic signed [7:0] theta_in;
   logic signed [7:0] z_in;
   logic              out_valid;
   logic              out_ready;
   logic signed [9:0] x_out;
   logic signed [9:0] y_out;
   logic signed [7:0] z_out;

   int testsRun    = 0;
   int testsFailed = 0;

   typedef struct {
      int r;
      int theta;
      int z;
      int expX;
      int expY;
      int tol;
   } vec_t;

   vec_t vecs[5];

   cyl_to_rect dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .r_in     (r_in),
      .theta_in (theta_in),
      .z_in     (z_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .x_out    (x_out),
      .y_out    (y_out),
      .z_out    (z_out)
   );

   always #5 clk = ~clk;

   // Reference: the rotation algorithm in plain integer arithmetic, run start to finish in one call
   function automatic void refModel(input int r, input int theta, output int x, output int y);
      int rs, z, xn, yn;
      int angles[8] = '{720, 425, 225, 114, 57, 29, 14, 7};
`ifdef CYL2RECT_GAIN_COMP_EN
      rs = (r * 155) / 256;
`else
      rs = r;
`endif
      x = rs;
      y = 0;
      z = theta * 16;
      if (theta > 90) begin
         x = 0; y = rs; z = (theta - 90) * 16;
      end else if (theta < -90) begin
         x = 0; y = -rs; z = (theta + 90) * 16;
      end
      for (int i = 0; i < 8; i++) begin
         if (z >= 0) begin
            xn = x - (y >>> i); yn = y + (x >>> i); z = z - angles[i];
         end else begin
            xn = x + (y >>> i); yn = y - (x >>> i); z = z + angles[i];
         end
         x = xn;
         y = yn;
      end
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
      testsRun++;
      if (actual > expected + tol || actual < expected - tol) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d (tol %0d)", name, actual, expected, tol);
      end
   endtask

   task automatic applyStimulus(input int r, input int theta, input int z, output int lat);
      @(negedge clk);
      checkOutput("in_ready_before_accept", int'(in_ready), 1, 0);
      in_valid = 1'b1;
      r_in     = r[7:0];
      theta_in = theta[7:0];
      z_in     = z[7:0];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      r_in     = 8'($urandom);
      theta_in = 8'($urandom);
      z_in     = 8'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic releaseResult();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("in_ready_after_release", int'(in_ready), 1, 0);
      checkOutput("out_valid_after_release", int'(out_valid), 0, 0);
   endtask

   initial begin
      int lat, ex, ey, r, th, z, validSeen;

`ifdef CYL2RECT_GAIN_COMP_EN
      vecs[0] = '{r: 100, theta: 0,    z: -5, expX: 99,  expY: 0,   tol: 3};
      vecs[1] = '{r: 100, theta: 90,   z: 7,  expX: 0,   expY: 99,  tol: 3};
      vecs[2] = '{r: 100, theta: 127,  z: 0,  expX: -60, expY: 79,  tol: 3};
      vecs[3] = '{r: 100, theta: -128, z: 12, expX: -61, expY: -78, tol: 3};
      vecs[4] = '{r: 0,   theta: 45,   z: -1, expX: 0,   expY: 0,   tol: 0};
`else
      vecs[0] = '{r: 100, theta: 0,    z: -5, expX: 165,  expY: 0,    tol: 3};
      vecs[1] = '{r: 100, theta: 90,   z: 7,  expX: 0,    expY: 165,  tol: 3};
      vecs[2] = '{r: 100, theta: 127,  z: 0,  expX: -99,  expY: 131,  tol: 5};
      vecs[3] = '{r: 100, theta: -128, z: 12, expX: -101, expY: -130, tol: 5};
      vecs[4] = '{r: 0,   theta: 45,   z: -1, expX: 0,    expY: 0,    tol: 0};
`endif

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      r_in      = '0;
      theta_in  = '0;
      z_in      = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", int'(in_ready), 1, 0);
      checkOutput("reset_out_valid", int'(out_valid), 0, 0);
      checkOutput("reset_x", int'(x_out), 0, 0);
      checkOutput("reset_y", int'(y_out), 0, 0);
      checkOutput("reset_z", int'(z_out), 0, 0);
      rst = 1'b0;

      $display("[TB] directed vectors");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].r, vecs[i].theta, vecs[i].z, lat);
         checkOutput("dir_latency", lat, 9, 0);
         checkOutput("dir_x", int'(x_out), vecs[i].expX, vecs[i].tol);
         checkOutput("dir_y", int'(y_out), vecs[i].expY, vecs[i].tol);
         checkOutput("dir_z", int'(z_out), vecs[i].z, 0);
         releaseResult();
      end

      $display("[TB] randomized vectors");
      for (int i = 0; i < 30; i++) begin
         r  = int'($urandom_range(0, 255));
         th = int'($urandom_range(0, 255)) - 128;
         z  = int'($urandom_range(0, 255)) - 128;
         refModel(r, th, ex, ey);
         applyStimulus(r, th, z, lat);
         checkOutput("rand_latency", lat, 9, 0);
         checkOutput("rand_x", int'(x_out), ex, 0);
         checkOutput("rand_y", int'(y_out), ey, 0);
         checkOutput("rand_z", int'(z_out), z, 0);
         releaseResult();
      end

      $display("[TB] back-pressure in DONE");
      refModel(100, 45, ex, ey);
      applyStimulus(100, 45, 33, lat);
      checkOutput("hold_latency", lat, 9, 0);
      in_valid = 1'b1;
      r_in     = 8'd17;
      theta_in = -8'sd60;
      z_in     = 8'sd99;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checkOutput("hold_x", int'(x_out), ex, 0);
         checkOutput("hold_y", int'(y_out), ey, 0);
         checkOutput("hold_z", int'(z_out), 33, 0);
         checkOutput("hold_in_ready", int'(in_ready), 0, 0);
         checkOutput("hold_out_valid", int'(out_valid), 1, 0);
      end
      in_valid = 1'b0;
      releaseResult();

      $display("[TB] reset during iteration");
      @(negedge clk);
      in_valid = 1'b1;
      r_in     = 8'd200;
      theta_in = 8'sd30;
      z_in     = 8'sd44;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_out_valid", int'(out_valid), 0, 0);
      checkOutput("rst_x", int'(x_out), 0, 0);
      checkOutput("rst_y", int'(y_out), 0, 0);
      checkOutput("rst_z", int'(z_out), 0, 0);
      checkOutput("rst_in_ready", int'(in_ready), 1, 0);
      validSeen = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) validSeen++;
      end
      checkOutput("rst_no_stale_result", validSeen, 0, 0);
      applyStimulus(50, 0, 0, lat);
      checkOutput("post_rst_latency", lat, 9, 0);
`ifdef CYL2RECT_GAIN_COMP_EN
      checkOutput("post_rst_x", int'(x_out), 49, 3);
`else
      checkOutput("post_rst_x", int'(x_out), 82, 3);
`endif
      checkOutput("post_rst_y", int'(y_out), 0, 3);
      releaseResult();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/cyl_to_rect.md
CYL_TO_RECT -- requirements
Module: cyl_to_rect

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  r_in/theta_in/z_in valid.
REQ-005 in_ready  out  1  block can accept input; high only in IDLE.
REQ-006 r_in  in  8  unsigned radius, 0..255.
REQ-007 theta_in  in  8  signed angle, integer degrees, -128..127.
REQ-008 z_in  in  8  signed height, passed through.
REQ-009 out_valid  out  1  x_out/y_out/z_out valid; high only in DONE.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 x_out  out  10  signed, approximately r*cos(theta).
REQ-012 y_out  out  10  signed, approximately r*sin(theta).
REQ-013 z_out  out  8  signed, equal to captured z_in.

Function
REQ-014 The FSM SHALL have states IDLE, ITER and DONE, and SHALL transition IDLE->ITER on in_valid&in_ready, ITER->DONE after iteration 7, and DONE->IDLE on out_ready.
REQ-015 On accept, the block SHALL load X0=rs, Y0=0, Z0=theta*16 (12-bit signed, 4 fraction bits), iter=0 and z_out=z_in, where rs is the radius after optional gain compensation (REQ-025/026).
REQ-016 The quadrant fold SHALL apply on accept:
- theta>90: X0=0, Y0=+rs, Z0=(theta-90)*16.
- theta<-90: X0=0, Y0=-rs, Z0=(theta+90)*16.
REQ-017 X and Y SHALL be 12-bit signed; all shifts SHALL be arithmetic.
REQ-018 Each ITER cycle i (0..7) SHALL update as follows:
- Z>=0: X-=Y>>>i, Y+=X>>>i, Z-=A[i].
- Z<0: X+=Y>>>i, Y-=X>>>i, Z+=A[i].
- All three updates use pre-update values.
REQ-019 The angle table SHALL be A[0..7]=720,425,225,114,57,29,14,7 (atan(2^-i) in degrees x16).
REQ-020 On the iter=7 update, x_out/y_out SHALL take X_new[9:0]/Y_new[9:0], and out_valid SHALL rise on the next cycle, which is 9 clocks after the accept edge.
REQ-021 In DONE, outputs SHALL be held stable until out_ready is seen high on a clock edge; in_ready SHALL return high on the following cycle.
REQ-022 in_valid SHALL be ignored outside IDLE, and inputs SHALL be sampled only on the accept edge.
REQ-023 r_in=0 SHALL yield x_out=y_out=0 for any theta.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL set:
- state=IDLE and iter=0.
- X=Y=Z=0.
- x_out=y_out=z_out=0 and out_valid=0.
- in_ready=1 from the first cycle after reset.
- An in-flight conversion is discarded, with no result produced.

Configuration
REQ-025 With macro CYL2RECT_GAIN_COMP_EN defined, rs SHALL be (r_in*155)>>8 (floor), compensating the CORDIC gain of about 1.6468, so |output| is about r.
REQ-026 Without CYL2RECT_GAIN_COMP_EN, rs SHALL equal r_in; outputs are then scaled by about 1.6468 (max about 420, within 10-bit signed), with identical latency and handshake.

Verification
REQ-027 The bench SHALL cover these scenarios (macro defined, tolerance ±3 LSB unless stated):
- r=100, theta=0, z=-5 -> x=99, y=0, z_out=-5; out_valid exactly 9 clocks after accept.
- r=100, theta=90 -> x=0, y=99. r=100, theta=127 -> x=-60, y=79.
- r=100, theta=-128 -> x=-61, y=-78. r=0, theta=45 -> x=0, y=0, exact.
- out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored. Release -> in_ready=1 next cycle.
- rst pulsed at iteration 4 -> next cycle out_valid=0, outputs 0, in_ready=1; a following r=50, theta=0 -> x=49.
- Macro undefined, r=100, theta=0 -> x=165 (±3), y=0, same 9-cycle latency.
